ps2_uart_frame_ctrl: RTL and testbench

- Bridges the PS/2 receiver to the UART transmitter.
- Each keyboard scancode goes into a parametrised FIFO. Each code is then sent as a fixed 4-byte frame: SYNC, ADDR, DATA, CHK.
- Frames are spaced by a programmable minimum inter-frame gap, and each byte uses the TX_En/TX_Done handshake.
- Replaces the single-byte, fixed 1 s paced controller. Codes are buffered, not overwritten.

---
 rtl/ps2_uart_pkg.sv | 26 ++
 rtl/ps2_code_fifo.sv | 64 ++++++
 rtl/ps2_uart_frame_ctrl.sv | 123 ++++++++++++
 tb/tb_ps2_uart_frame_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_uart_pkg.sv
// Shared types and constants for the PS/2-to-UART framing bridge.
package ps2_uart_pkg;

  localparam int unsigned CODE_W    = 8;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  localparam logic [CODE_W-1:0] DEF_SYNC_BYTE = 8'hAA;
  localparam logic [CODE_W-1:0] DEF_DEV_ADDR  = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  // Frame check byte: XOR of the three preceding frame bytes.
  function automatic logic [CODE_W-1:0] frame_chk(input logic [CODE_W-1:0] sync_b,
                                                  input logic [CODE_W-1:0] addr_b,
                                                  input logic [CODE_W-1:0] data_b);
    return sync_b ^ addr_b ^ data_b;
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// Circular scancode buffer; a push into a full FIFO is discarded and flagged.
module ps2_code_fifo
  import ps2_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout_c,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CW-1:0]     count_nxt;

  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      drop   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      drop  <= push && !do_push;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout_c = mem[rd_ptr];

endmodule

// File: rtl/ps2_uart_frame_ctrl.sv
// Buffers PS/2 scancodes and sends each as a SYNC/ADDR/DATA/CHK frame over the
// UART TX_En/TX_Done handshake, with a minimum gap between frames.
module ps2_uart_frame_ctrl
  import ps2_uart_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter int unsigned       GAP_CYCLES = 50_000_000,
  parameter int unsigned       GAP_W      = 26,
  parameter logic [CODE_W-1:0] SYNC_BYTE  = DEF_SYNC_BYTE,
  parameter logic [CODE_W-1:0] DEV_ADDR   = DEF_DEV_ADDR,
  localparam int unsigned      CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              PS2_Done_Sig,
  input  logic [CODE_W-1:0] KeyBoardData,
  input  logic              TX_Done_Sig,
  output logic              TX_En_Sig,
  output logic [CODE_W-1:0] TX_Data,
  output logic [CNT_W-1:0]  Fifo_Count,
  output logic              Fifo_Full,
  output logic              Drop_Sig
);

  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  state_t             state;
  state_t             state_nxt;
  logic               ps2_prev;
  logic               push_c;
  logic               pop_c;
  logic               fifo_empty;
  logic [CODE_W-1:0]  fifo_dout;
  logic [CODE_W-1:0]  data_q;
  logic [IDX_W-1:0]   idx;
  logic               last_idx_c;
  logic [GAP_W-1:0]   gap_cnt;
  logic               gap_ok;
  logic               gap_done_c;

  assign push_c     = PS2_Done_Sig && !ps2_prev;
  assign pop_c      = (state == ST_LOAD);
  assign last_idx_c = (idx == IDX_W'(FRAME_LEN - 1));
  assign gap_done_c = (gap_cnt >= GAP_W'(GAP_LAST));

  ps2_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (CLK),
    .rst_n  (RSTn),
    .push   (push_c),
    .pop    (pop_c),
    .din    (KeyBoardData),
    .dout_c (fifo_dout),
    .count  (Fifo_Count),
    .full   (Fifo_Full),
    .empty  (fifo_empty),
    .drop   (Drop_Sig)
  );

  function automatic logic [CODE_W-1:0] frame_byte(input logic [IDX_W-1:0] i,
                                                   input logic [CODE_W-1:0] d);
    case (i)
      IDX_W'(0): return SYNC_BYTE;
      IDX_W'(1): return DEV_ADDR;
      IDX_W'(2): return d;
      default:   return frame_chk(SYNC_BYTE, DEV_ADDR, d);
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (!fifo_empty && gap_ok) state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_SEND;
      ST_SEND:    if (TX_Done_Sig) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = last_idx_c ? ST_GAP : ST_SEND;
      ST_GAP:     if (gap_done_c) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath; the gap counter only advances in GAP and stops at its last value.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ps2_prev  <= 1'b0;
      data_q    <= '0;
      idx       <= '0;
      gap_cnt   <= GAP_W'(GAP_LAST);
      gap_ok    <= 1'b1;
      TX_En_Sig <= 1'b0;
      TX_Data   <= '0;
    end else begin
      ps2_prev  <= PS2_Done_Sig;
      TX_En_Sig <= (state_nxt == ST_SEND);
      case (state)
        ST_LOAD: begin
          data_q  <= fifo_dout;
          idx     <= '0;
          TX_Data <= SYNC_BYTE;
        end
        ST_RELEASE: begin
          if (!last_idx_c) begin
            idx     <= idx + IDX_W'(1);
            TX_Data <= frame_byte(idx + IDX_W'(1), data_q);
          end else begin
            gap_cnt <= '0;
            gap_ok  <= 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_done_c) gap_ok  <= 1'b1;
          else            gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_uart_frame_ctrl.sv
// Scoreboard bench: stimulus queues expected frame bytes, a negedge monitor
// pops and compares every byte the UART side accepts.
module tb_ps2_uart_frame_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 16;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       PS2_Done_Sig;
  logic [7:0] KeyBoardData;
  logic       TX_Done_Sig;
  logic       TX_En_Sig;
  logic [7:0] TX_Data;
  logic [2:0] Fifo_Count;
  logic       Fifo_Full;
  logic       Drop_Sig;

  ps2_uart_frame_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP),
    .GAP_W      (8)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .PS2_Done_Sig (PS2_Done_Sig),
    .KeyBoardData (KeyBoardData),
    .TX_Done_Sig  (TX_Done_Sig),
    .TX_En_Sig    (TX_En_Sig),
    .TX_Data      (TX_Data),
    .Fifo_Count   (Fifo_Count),
    .Fifo_Full    (Fifo_Full),
    .Drop_Sig     (Drop_Sig)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_fail = 0;

  logic [7:0] exp_bytes[$];
  int exp_drops = 0;
  int drops_seen = 0;

  // UART responder knobs
  int ack_delay = 5;
  bit uart_stall = 0;
  bit spurious = 0;

  // Monitor state, read by the directed sequence
  int pos = 0;
  int frames_started = 0;
  int frames_done = 0;

  function automatic void chk(input string name, input int unsigned act, input int unsigned want);
    n_vec++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic void chk_ge(input string name, input int unsigned act, input int unsigned min);
    n_vec++;
    if (act < min) begin
      n_fail++;
      $display("FAIL %s: got %0d expected >= %0d (t=%0t)", name, act, min, $time);
    end
  endfunction

  // Reference frame: SYNC, ADDR, DATA, XOR of the three.
  task automatic push_exp(input logic [7:0] code);
    exp_bytes.push_back(8'hAA);
    exp_bytes.push_back(8'h01);
    exp_bytes.push_back(code);
    exp_bytes.push_back(8'hAA ^ 8'h01 ^ code);
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Raise PS2_Done_Sig with a code for 'hold' cycles; code is valid only on the first.
  task automatic push_code(input logic [7:0] code, input int hold);
    PS2_Done_Sig = 1'b1;
    KeyBoardData = code;
    @(posedge CLK); #1;
    KeyBoardData = 8'($urandom);
    for (int i = 1; i < hold; i++) begin @(posedge CLK); #1; end
    PS2_Done_Sig = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (exp_bytes.size() != 0 && t < limit) begin @(posedge CLK); #1; t++; end
    chk("drain", exp_bytes.size(), 0);
  endtask

  task automatic check_latency(input string name);
    int lat = 0;
    while (!TX_En_Sig && lat < 60) begin @(posedge CLK); #1; lat++; end
    n_vec++;
    if (lat > 2) begin
      n_fail++;
      $display("FAIL %s: got latency %0d expected <= 2", name, lat);
    end
  endtask

  // UART responder
  initial begin
    int wcnt = 0;
    TX_Done_Sig = 1'b0;
    forever begin
      @(posedge CLK); #1;
      TX_Done_Sig = 1'b0;
      if (!RSTn) begin
        wcnt = 0;
      end else if (TX_En_Sig && !uart_stall) begin
        if (wcnt >= ack_delay) begin
          TX_Done_Sig = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (spurious && !TX_En_Sig && $urandom_range(0, 7) == 0) TX_Done_Sig = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int chk_low = 0;
    bit gap_armed = 0;
    bit prev_en = 0;
    logic [7:0] prev_data = '0;
    int mcyc = 0;
    int last_done = 0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        pos = 0; chk_low = 0; gap_armed = 0; prev_en = 0;
      end else begin
        mcyc++;
        if (chk_low == 1) begin
          chk("release_low", 32'(TX_En_Sig), 0);
          chk_low = 2;
        end else if (chk_low == 2) begin
          chk("resend", 32'(TX_En_Sig), 1);
          chk_low = 0;
        end
        if (TX_En_Sig && prev_en) chk("data_stable", 32'(TX_Data), 32'(prev_data));
        if (TX_En_Sig && !prev_en && pos == 0) begin
          frames_started++;
          // earliest restart: RELEASE, GAP cycles, IDLE, LOAD after the last ack
          if (gap_armed) chk_ge("frame_gap", mcyc - last_done, GAP + 4);
          gap_armed = 0;
        end
        if (TX_En_Sig && TX_Done_Sig) begin
          if (exp_bytes.size() == 0) chk("unexpected_byte", 32'(TX_Data), 32'hFFFF_FFFF);
          else chk($sformatf("tx_byte%0d", pos), 32'(TX_Data), 32'(exp_bytes.pop_front()));
          if (pos == 3) begin
            pos = 0; gap_armed = 1; last_done = mcyc; frames_done++;
          end else begin
            pos++; chk_low = 1;
          end
        end
        if (Drop_Sig) drops_seen++;
        prev_en = TX_En_Sig;
        prev_data = TX_Data;
      end
    end
  end

  // Watchdog
  initial begin
    repeat (80000) @(posedge CLK);
    n_fail++;
    $display("FAIL watchdog: run exceeded cycle budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] codes[6];
    logic [7:0] c;
    int f0, t, base_f, base_c;

    RSTn = 1'b0;
    PS2_Done_Sig = 1'b0;
    KeyBoardData = '0;
    idle_cyc(3);
    chk("rst_en", 32'(TX_En_Sig), 0);
    chk("rst_count", 32'(Fifo_Count), 0);
    chk("rst_full", 32'(Fifo_Full), 0);
    chk("rst_drop", 32'(Drop_Sig), 0);
    RSTn = 1'b1;
    idle_cyc(2);
    chk("post_rst_en", 32'(TX_En_Sig), 0);

    // Single code
    ack_delay = 5;
    push_exp(8'h1C);
    push_code(8'h1C, 1);
    chk("single_count1", 32'(Fifo_Count), 1);
    check_latency("single_latency");
    chk("single_count0", 32'(Fifo_Count), 0);
    wait_drain(500);
    idle_cyc(GAP + 10);

    // Gap enforcement, back-to-back codes
    push_exp(8'h32);
    push_code(8'h32, 1);
    idle_cyc(1);
    push_exp(8'h21);
    push_code(8'h21, 1);
    wait_drain(1000);
    idle_cyc(GAP + 10);

    // Overflow with UART stalled
    uart_stall = 1;
    for (int i = 0; i < 6; i++) codes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      push_code(codes[i], 1);
      if (i < 5) push_exp(codes[i]); else exp_drops++;
      if (i == 1) chk("ovf_first_popped", 32'(Fifo_Count), 1);
      if (i == 3) chk("ovf_full_4th", 32'(Fifo_Full), 0);
      if (i == 4) begin
        chk("ovf_full_5th", 32'(Fifo_Full), 1);
        chk("ovf_nodrop_5th", 32'(Drop_Sig), 0);
      end
      if (i == 5) begin
        chk("ovf_drop_6th", 32'(Drop_Sig), 1);
        chk("ovf_count_6th", 32'(Fifo_Count), DEPTH);
      end
      idle_cyc(1);
    end
    chk("ovf_drop_once", 32'(Drop_Sig), 0);

    // Push on the LOAD cycle of the next frame while full
    ack_delay = 2;
    f0 = frames_done;
    uart_stall = 0;
    t = 0;
    do begin @(negedge CLK); #1; t++; end while (frames_done == f0 && t < 500);
    chk("frame1_done", 32'(frames_done != f0), 1);
    repeat (GAP + 3) @(posedge CLK);
    #1;
    chk("sim_full_before", 32'(Fifo_Full), 1);
    c = 8'($urandom);
    push_exp(c);
    push_code(c, 1);
    chk("sim_count", 32'(Fifo_Count), DEPTH);
    chk("sim_nodrop", 32'(Drop_Sig), 0);
    wait_drain(2000);
    idle_cyc(GAP + 10);

    // Held PS2_Done_Sig level
    ack_delay = 1;
    c = 8'($urandom);
    push_exp(c);
    push_code(c, 100);
    wait_drain(500);
    idle_cyc(GAP + 10);
    chk("held_no_extra", exp_bytes.size(), 0);
    chk("held_count", 32'(Fifo_Count), 0);

    // Reset in the middle of byte 2
    ack_delay = 5;
    push_exp(8'h5A);
    push_code(8'h5A, 1);
    idle_cyc(1);
    push_exp(8'h77);
    push_code(8'h77, 1);
    t = 0;
    do begin @(negedge CLK); #1; t++; end while (!(pos == 2 && TX_En_Sig) && t < 400);
    chk("reach_byte2", 32'(pos == 2 && TX_En_Sig), 1);
    chk("pre_rst_count", 32'(Fifo_Count), 1);
    RSTn = 1'b0;
    #1;
    chk("midrst_en", 32'(TX_En_Sig), 0);
    chk("midrst_count", 32'(Fifo_Count), 0);
    exp_bytes.delete();
    idle_cyc(2);
    RSTn = 1'b1;
    idle_cyc(2);
    push_exp(8'h3B);
    push_code(8'h3B, 1);
    check_latency("rst_latency");
    chk("rst_first_byte", 32'(TX_Data), 8'hAA);
    wait_drain(500);
    idle_cyc(GAP + 10);

    // Randomized traffic
    spurious = 1;
    base_f = frames_started;
    base_c = 0;
    for (int n = 0; n < 40; n++) begin
      t = 0;
      while ((base_c - (frames_started - base_f)) > int'(DEPTH) - 2 && t < 2000) begin
        @(posedge CLK); #1; t++;
      end
      ack_delay = $urandom_range(0, 4);
      c = 8'($urandom);
      push_exp(c);
      push_code(c, $urandom_range(1, 3));
      base_c++;
      idle_cyc($urandom_range(1, 25));
    end
    wait_drain(20000);
    spurious = 0;
    idle_cyc(GAP + 10);

    chk("drops_total", drops_seen, exp_drops);
    chk("final_count", 32'(Fifo_Count), 0);
    chk("final_en", 32'(TX_En_Sig), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
